// File: rtl/dlfloat16_round_pack_if.sv
// Valid/ready stream carrying a data word and its 5-bit exception vector
// {invalid, inexact, overflow, underflow, div_zero}.
interface dlfloat16_round_pack_if #(
  parameter int DATA_W = 16
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [4:0]        exc;

  modport master (
    output valid,
    output data,
    output exc,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  exc,
    output ready
  );
endinterface

// File: rtl/dlfloat16_round_pack.sv
// DLFloat16 round/saturate/pack: 20-bit extended add/sub result in, packed 16-bit word out.
// Two-stage valid/ready pipeline; define DLF_ROUND_PACK_RTZ_EN to add the rnd_mode truncate input.
module dlfloat16_round_pack #(
  parameter logic [14:0] MAX_FINITE = 15'h7DFE,
  parameter logic [15:0] NAN_WORD   = 16'hFFFF,
  parameter int          CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dlfloat16_round_pack_if.slave  in_if,
  dlfloat16_round_pack_if.master out_if,
`ifdef DLF_ROUND_PACK_RTZ_EN
  input  logic                   rnd_mode,
`endif
  input  logic                   flag_clr,
  output logic [4:0]             sticky_exc,
  output logic [CNT_W-1:0]       res_cnt
);

  localparam int EXC_INV = 4;
  localparam int EXC_INX = 3;
  localparam int EXC_OVF = 2;

  // Single stall for the whole pipe: only the output register can be blocked.
  logic stall;
  logic out_fire;

  logic              s1_valid_q,   s1_valid_d;
  logic              s1_sign_q,    s1_sign_d;
  logic [15:0]       s1_mag_q,     s1_mag_d;
  logic              s1_inexact_q, s1_inexact_d;
  logic [4:0]        s1_exc_q,     s1_exc_d;
  logic              s1_special_q, s1_special_d;

  logic              out_valid_q,  out_valid_d;
  logic [15:0]       out_data_q,   out_data_d;
  logic [4:0]        out_exc_q,    out_exc_d;
  logic [4:0]        sticky_q,     sticky_d;
  logic [CNT_W-1:0]  res_cnt_q,    res_cnt_d;

  assign stall       = out_valid_q & ~out_if.ready;
  assign out_fire    = out_valid_q & out_if.ready;
  assign in_if.ready = ~stall;

  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_data_q;
  assign out_if.exc   = out_exc_q;
  assign sticky_exc   = sticky_q;
  assign res_cnt      = res_cnt_q;

  logic        in_sign;
  logic [5:0]  in_exp;
  logic [8:0]  in_frac;
  logic        in_guard;
  logic        in_sticky;
  logic        in_lsb;
  logic        in_special;
  logic        in_zero;
  logic        round_up;
  logic [15:0] rounded_mag;

  assign in_sign    = in_if.data[19];
  assign in_exp     = in_if.data[18:13];
  assign in_frac    = in_if.data[12:4];
  assign in_guard   = in_if.data[3];
  assign in_sticky  = |in_if.data[2:0];
  assign in_lsb     = in_if.data[4];
  assign in_special = &in_if.data[18:4];
  assign in_zero    = (in_exp == 6'd0);

`ifdef DLF_ROUND_PACK_RTZ_EN
  assign round_up = ~rnd_mode & in_guard & (in_sticky | in_lsb);
`else
  assign round_up = in_guard & (in_sticky | in_lsb);
`endif

  // Fraction increment ripples into the exponent; bit 15 catches exponent overflow.
  assign rounded_mag = {1'b0, in_exp, in_frac} + {15'd0, round_up};

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_sign_d    = s1_sign_q;
    s1_mag_d     = s1_mag_q;
    s1_inexact_d = s1_inexact_q;
    s1_exc_d     = s1_exc_q;
    s1_special_d = s1_special_q;
    if (!stall) begin
      s1_valid_d = in_if.valid;
      if (in_if.valid) begin
        s1_sign_d    = in_sign;
        s1_exc_d     = in_if.exc;
        s1_special_d = in_special;
        if (in_special || in_zero) begin
          s1_mag_d     = 16'd0;
          s1_inexact_d = 1'b0;
        end else begin
          s1_mag_d     = rounded_mag;
          s1_inexact_d = in_guard | in_sticky;
        end
      end
    end
  end

  logic sat_hit;
  assign sat_hit = (s1_mag_q > {1'b0, MAX_FINITE});

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_exc_d   = out_exc_q;
    if (!stall) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_exc_d = s1_exc_q;
        if (s1_special_q) begin
          out_data_d         = NAN_WORD;
          out_exc_d[EXC_INV] = 1'b1;
        end else if (sat_hit) begin
          out_data_d         = {s1_sign_q, MAX_FINITE};
          out_exc_d[EXC_OVF] = 1'b1;
          out_exc_d[EXC_INX] = 1'b1;
        end else begin
          out_data_d         = {s1_sign_q, s1_mag_q[14:0]};
          out_exc_d[EXC_INX] = s1_exc_q[EXC_INX] | s1_inexact_q;
        end
      end
    end
  end

  // A clear coinciding with a handshake wipes old flags but keeps this result's flags.
  always_comb begin
    sticky_d  = (flag_clr ? 5'd0 : sticky_q) | (out_fire ? out_exc_q : 5'd0);
    res_cnt_d = res_cnt_q;
    if (out_fire && (res_cnt_q != {CNT_W{1'b1}})) begin
      res_cnt_d = res_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_mag_q     <= 16'd0;
      s1_inexact_q <= 1'b0;
      s1_exc_q     <= 5'd0;
      s1_special_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 16'd0;
      out_exc_q    <= 5'd0;
      sticky_q     <= 5'd0;
      res_cnt_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_mag_q     <= s1_mag_d;
      s1_inexact_q <= s1_inexact_d;
      s1_exc_q     <= s1_exc_d;
      s1_special_q <= s1_special_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_exc_q    <= out_exc_d;
      sticky_q     <= sticky_d;
      res_cnt_q    <= res_cnt_d;
    end
  end

endmodule

// File: tb/tb_dlfloat16_round_pack.sv
// Self-checking bench for dlfloat16_round_pack: directed vectors, backpressure,
// sticky/clear, async reset and a random stream against an arithmetic reference model.
module tb_dlfloat16_round_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flag_clr = 1'b0;
  logic        rnd_mode = 1'b0;
  logic [4:0]  sticky_exc;
  logic [15:0] res_cnt;

  dlfloat16_round_pack_if #(.DATA_W(20)) in_bus ();
  dlfloat16_round_pack_if #(.DATA_W(16)) out_bus ();

  int checks = 0;
  int errors = 0;

  logic [20:0] exp_q[$];
  logic [4:0]  sticky_m = 5'd0;
  logic [15:0] cnt_m = 16'd0;

  always #5 clk = ~clk;

  dlfloat16_round_pack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (in_bus),
    .out_if     (out_bus),
`ifdef DLF_ROUND_PACK_RTZ_EN
    .rnd_mode   (rnd_mode),
`endif
    .flag_clr   (flag_clr),
    .sticky_exc (sticky_exc),
    .res_cnt    (res_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: treat bits 18:4 as an integer magnitude, bits 3:0 as the discarded remainder.
  function automatic logic [20:0] ref_model(input logic [19:0] d, input logic [4:0] e,
                                            input logic rtz);
    int unsigned mag, rem, r;
    logic        up;
    mag = 32'(d[18:4]);
    rem = 32'(d[3:0]);
    if (mag == 32'h7FFF) return {e | 5'b10000, 16'hFFFF};
    if (d[18:13] == 6'd0) return {e, d[19], 15'h0};
    up = !rtz && ((rem > 8) || (rem == 8 && (mag % 2) == 1));
    r = mag + 32'(up);
    if (r > 32'h7DFE) return {e | 5'b01100, d[19], 15'h7DFE};
    return {e | ((rem != 0) ? 5'b01000 : 5'b00000), d[19], r[14:0]};
  endfunction

  // One clock: drive at negedge, sample just before posedge, check state at next negedge.
  task automatic step(input logic v, input logic [19:0] d, input logic [4:0] e,
                      input logic ordy, input logic clr, output logic fired);
    logic        out_fire;
    logic [20:0] expv;
    logic [4:0]  fire_exc;
    in_bus.valid  = v;
    in_bus.data   = d;
    in_bus.exc    = e;
    out_bus.ready = ordy;
    flag_clr      = clr;
    fire_exc      = 5'd0;
    #1;
    fired    = v & in_bus.ready;
    out_fire = out_bus.valid & ordy;
    if (out_bus.valid && !ordy) chk("in_ready_stall", 32'(in_bus.ready), 32'd0);
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'd1, 32'd0);
      end else begin
        expv     = exp_q.pop_front();
        fire_exc = expv[20:16];
        chk("out_data", 32'(out_bus.data), 32'(expv[15:0]));
        chk("out_exc", 32'(out_bus.exc), 32'(expv[20:16]));
      end
    end
    sticky_m = (clr ? 5'd0 : sticky_m) | fire_exc;
    if (out_fire && cnt_m != 16'hFFFF) cnt_m++;
    if (fired) exp_q.push_back(ref_model(d, e, rnd_mode));
    @(posedge clk);
    @(negedge clk);
    chk("sticky_exc", 32'(sticky_exc), 32'(sticky_m));
    chk("res_cnt", 32'(res_cnt), 32'(cnt_m));
  endtask

  task automatic do_reset();
    in_bus.valid  = 1'b0;
    in_bus.data   = 20'd0;
    in_bus.exc    = 5'd0;
    out_bus.ready = 1'b1;
    flag_clr      = 1'b0;
    rnd_mode      = 1'b0;
    rst_n         = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    sticky_m = 5'd0;
    cnt_m    = 16'd0;
  endtask

  task automatic single(input string tag, input logic [19:0] d, input logic [4:0] e,
                        input logic [15:0] xd, input logic [4:0] xe);
    logic f;
    step(1'b1, d, e, 1'b1, 1'b0, f);
    chk({tag, "_accept"}, 32'(f), 32'd1);
    chk({tag, "_lat1"}, 32'(out_bus.valid), 32'd0);
    step(1'b0, 20'd0, 5'd0, 1'b1, 1'b0, f);
    chk({tag, "_lat2"}, 32'(out_bus.valid), 32'd1);
    chk({tag, "_data"}, 32'(out_bus.data), 32'(xd));
    chk({tag, "_exc"}, 32'(out_bus.exc), 32'(xe));
    step(1'b0, 20'd0, 5'd0, 1'b1, 1'b0, f);
  endtask

  function automatic logic [19:0] rand_word();
    logic [19:0] w;
    w = 20'($urandom);
    case ($urandom_range(0, 7))
      0: w[18:4]  = 15'h7FFF;
      1: w[18:13] = 6'h00;
      2: w[18:13] = 6'h3E;
      3: w[18:4]  = 15'h7DFF;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    logic f;
    int   sent;
    in_bus.valid  = 1'b0;
    in_bus.data   = 20'd0;
    in_bus.exc    = 5'd0;
    out_bus.ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_bus.valid), 32'd0);
    chk("rst_out_data", 32'(out_bus.data), 32'd0);
    chk("rst_out_exc", 32'(out_bus.exc), 32'd0);
    chk("rst_sticky", 32'(sticky_exc), 32'd0);
    chk("rst_res_cnt", 32'(res_cnt), 32'd0);
    do_reset();

    single("tie_even",  20'h3E008, 5'd0,     16'h3E00, 5'b01000);
    single("above_half",20'h3E009, 5'd0,     16'h3E01, 5'b01000);
    single("carry",     20'h3FFF8, 5'd0,     16'h4000, 5'b01000);
    single("sat_pos",   20'h7DFF8, 5'd0,     16'h7DFE, 5'b01100);
    single("sat_neg",   20'hFDFF8, 5'd0,     16'hFDFE, 5'b01100);
    single("special",   20'hFFFF0, 5'd0,     16'hFFFF, 5'b10000);
    single("zero",      20'h80000, 5'd0,     16'h8000, 5'b00000);
    single("exc_pass",  20'h3E000, 5'b00011, 16'h3E00, 5'b00011);
    single("exact_max", 20'h7DFE0, 5'd0,     16'h7DFE, 5'b00000);

    // Sticky: overflow, then clear together with an inexact-only handshake, then clear alone
    do_reset();
    single("ovf", 20'h7DFF8, 5'd0, 16'h7DFE, 5'b01100);
    chk("sticky_ovf", 32'(sticky_exc), 32'h0C);
    step(1'b1, 20'h3E008, 5'd0, 1'b1, 1'b0, f);
    step(1'b0, 20'd0, 5'd0, 1'b1, 1'b0, f);
    step(1'b0, 20'd0, 5'd0, 1'b1, 1'b1, f);
    chk("sticky_clr_hs", 32'(sticky_exc), 32'h08);
    step(1'b0, 20'd0, 5'd0, 1'b1, 1'b1, f);
    chk("sticky_clr_only", 32'(sticky_exc), 32'h00);

    // Backpressure: four words, out_ready low for cycles 3-6
    do_reset();
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      step(sent < 4, rand_word(), 5'd0, !(c >= 3 && c <= 6), 1'b0, f);
      if (f) sent++;
    end
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(1'b0, 20'd0, 5'd0, 1'b1, 1'b0, f);
    chk("bp_drain", 32'(exp_q.size()), 32'd0);
    chk("bp_sent", 32'(sent), 32'd4);
    chk("bp_res_cnt", 32'(res_cnt), 32'd4);

    // Random stream with random stalls, exceptions and clears
    do_reset();
    for (int c = 0; c < 300; c++) begin
`ifdef DLF_ROUND_PACK_RTZ_EN
      rnd_mode = 1'($urandom_range(0, 1));
`endif
      step(1'($urandom_range(0, 1)), rand_word(),
           ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, f);
    end
    rnd_mode = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(1'b0, 20'd0, 5'd0, 1'b1, 1'b0, f);
    chk("rand_drain", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 3; i++) step(1'b1, 20'h3E009, 5'd0, 1'b1, 1'b0, f);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_bus.valid), 32'd0);
    chk("arst_out_data", 32'(out_bus.data), 32'd0);
    chk("arst_out_exc", 32'(out_bus.exc), 32'd0);
    chk("arst_sticky", 32'(sticky_exc), 32'd0);
    chk("arst_res_cnt", 32'(res_cnt), 32'd0);
    in_bus.valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    sticky_m = 5'd0;
    cnt_m    = 16'd0;
    single("restart", 20'h3E009, 5'd0, 16'h3E01, 5'b01000);
    chk("restart_cnt", 32'(res_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dlfloat16_round_pack.md
Name: dlfloat16_round_pack

Overview:
- Consumer end of the 20-bit extended-result interface driven by the DLFloat16 add/sub unit.
- Accepts the raw result `{sign, exp[5:0], frac_ext[12:0]}` plus its 5-bit exception vector, applies rounding and saturation, and emits the packed 16-bit DLFloat16 word.
- Two-stage valid/ready pipeline with a sticky exception accumulator, sitting between the arithmetic units and the writeback/result buffer.

Parameters:
- MAX_FINITE, 15'h7DFE, magnitude used on saturation; output is `{sign, MAX_FINITE}`.
- NAN_WORD, 16'hFFFF, output word for special (NaN/Inf) inputs.
- CNT_W, 16, width of the accepted-result counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept the input this cycle
- in_data  in  20  bit 19 sign; 18:13 exponent; 12:4 stored fraction; 3 guard; 2:0 sticky bits
- in_exc  in  5  upstream flags `{invalid, inexact, overflow, underflow, div_zero}`
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the output
- out_data  out  16  packed DLFloat16 result
- out_exc  out  5  per-result flags: in_exc ORed with flags raised locally
- flag_clr  in  1  clears the sticky flags
- sticky_exc  out  5  accumulated flags since reset or last clear
- res_cnt  out  CNT_W  count of results accepted by downstream (out_valid & out_ready); saturates at all-ones

Behaviour:
- Reset is asynchronous on rst_n. Reset values: out_valid=0, out_data=0, out_exc=0, sticky_exc=0, res_cnt=0, and both stage valid bits=0. Reset during an in-flight transfer discards it.
- Handshake:
  - Transfer occurs when valid and ready are both high.
  - Global stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - When stalled, both stages hold their contents, and out_data/out_exc stay stable.
- Latency: 2 cycles from input acceptance to out_valid. Throughput is 1 per cycle when out_ready is held high.
- Stage 1 (rounding, round-to-nearest-even):
  - G = bit 3; S = |bits 2:0; L = bit 4.
  - Round up when G & (S | L).
  - inexact_loc = G | S.
  - The 9-bit fraction increment carries into the exponent (7-bit internal sum).
  - Registered: sign, exp7, frac9, inexact_loc, in_exc, and a special flag.
- Special input: bits 18:4 all ones. Output is NAN_WORD, invalid is forced to 1, and no rounding is applied.
- Zero input: exponent 0. Output is `{sign, 15'h0}`; rounding bits are ignored; underflow is taken from in_exc only.
- Stage 2 (saturate/pack):
  - If `{exp7, frac9}` > `{1'b0, MAX_FINITE}`: out_data = `{sign, MAX_FINITE}`, with overflow and inexact set.
  - Otherwise out_data = `{sign, exp7[5:0], frac9}`.
  - out_exc = in_exc | local flags.
- Sticky accumulator:
  - On each output handshake, sticky_exc |= out_exc.
  - When flag_clr coincides with a handshake, sticky_exc = out_exc of that handshake: the clear applies first, then the new flags are ORed in.
  - flag_clr alone sets sticky_exc to 0 on the next edge.
- res_cnt increments on each output handshake and holds at 2^CNT_W-1.
- Bubble: in_valid=0 with no stall inserts an empty slot; the downstream stage still advances.

Optional Feature:
- Macro DLF_ROUND_PACK_RTZ_EN.
- When defined, adds input port rnd_mode (1 bit). Its value is captured with the data in stage 1.
  - rnd_mode=1: truncate; never round up.
  - inexact is still G | S.
  - Saturation still applies.
- When undefined: no port; RNE only.

Test Plan:
- Tie, even LSB: in_data=20'h3E008, in_exc=0 -> out_data=16'h3E00, out_exc=5'b01000, two cycles after acceptance.
- Above half: in_data=20'h3E009 -> out_data=16'h3E01, inexact set. Carry: in_data=20'h3FFF8 -> out_data=16'h4000.
- Saturation: in_data=20'h7DFF8 (sign 0) -> out_data=16'h7DFE, out_exc=5'b01100; the same input with bit 19 set -> 16'hFDFE.
- Special and zero:
  - in_data=20'hFFFF0 -> out_data=16'hFFFF, invalid=1.
  - in_data=20'h80000 -> 16'h8000, out_exc=0.
- Backpressure: stream 4 words with out_ready low for cycles 3-6 -> in_ready low while out_valid=1 & ~out_ready; no word lost or duplicated; res_cnt=4 at the end.
- Sticky and reset:
  - Overflow result, then flag_clr together with an inexact-only handshake -> sticky_exc=5'b01000.
  - Assert rst_n low mid-stream -> all outputs return to 0 asynchronously; the stream restarts cleanly.
